// File: rtl/muldiv_seq_pkg.sv
// Shared ISA constants and sequencer state type for the RV32M muldiv unit.
// Holds the M-extension funct3 encodings and the muldiv_state_t FSM enum.
package muldiv_seq_pkg;

    localparam int ISA__XLEN         = 32;
    localparam int ISA__FUNCT3_WIDTH = 3;

    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MUL    = 3'd0;
    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MULH   = 3'd1;
    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MULHSU = 3'd2;
    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_MULHU  = 3'd3;
    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_DIV    = 3'd4;
    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_DIVU   = 3'd5;
    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_REM    = 3'd6;
    localparam logic [ISA__FUNCT3_WIDTH-1:0] ISA__FUNCT3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration (shift-add multiply step or
// restoring-divide step). The divide half exists only with MULDIV_DIV_EN.
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int Width = ISA__XLEN
) (
`ifdef MULDIV_DIV_EN
    input  logic             div_i,
`endif
    input  logic [Width-1:0] hi_i,
    input  logic [Width-1:0] lo_i,
    input  logic [Width-1:0] m_i,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);

    logic [Width:0] sum;
    logic [Width:0] acc;
`ifdef MULDIV_DIV_EN
    logic [Width:0] sh;
    logic           ge;
`endif

    always_comb begin
        // {hi,lo} is the 2W accumulator; lo holds the unconsumed multiplier bits
        sum  = {1'b0, hi_i} + {1'b0, m_i};
        acc  = lo_i[0] ? sum : {1'b0, hi_i};
        hi_o = acc[Width:1];
        lo_o = {acc[0], lo_i[Width-1:1]};
`ifdef MULDIV_DIV_EN
        sh = {hi_i, lo_i[Width-1]};
        ge = (sh >= {1'b0, m_i});
        if (div_i) begin
            hi_o = ge ? (sh[Width-1:0] - m_i) : sh[Width-1:0];
            lo_o = {lo_i[Width-2:0], ge};
        end
`endif
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: bit-serial RV32M multiply/divide sequencer with valid/ready I/O.
// Define MULDIV_DIV_EN for the divider; otherwise div ops return 0 at once.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int Width = ISA__XLEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ISA__FUNCT3_WIDTH-1:0] funct3,
    input  logic [Width-1:0]             a,
    input  logic [Width-1:0]             b,
    input  logic                         flush,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [Width-1:0]             result,
    output logic                         busy
);

    localparam int CntW = $clog2(Width + 1);
    localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

    muldiv_state_t                state_q;
    logic [ISA__FUNCT3_WIDTH-1:0] op_q;
    logic                         neg_q;
    logic [Width-1:0]             m_q;
    logic [Width-1:0]             hi_q;
    logic [Width-1:0]             lo_q;
    logic [Width-1:0]             result_q;
    logic [CntW-1:0]              cnt_q;
    logic                         ready_q;
    logic                         valid_q;
    logic                         busy_q;

    logic             is_div;
    logic             sgn_a;
    logic             sgn_b;
    logic             neg_d;
    logic             fast_d;
    logic [Width-1:0] abs_a;
    logic [Width-1:0] abs_b;
    logic [Width-1:0] fast_res_d;
    logic [Width-1:0] hi_d;
    logic [Width-1:0] lo_d;
    logic [Width-1:0] hi_neg;
    logic [Width-1:0] final_d;

    always_comb begin
        is_div = funct3[2];
        sgn_a  = a[Width-1] & ((funct3 == ISA__FUNCT3_MULH) |
                               (funct3 == ISA__FUNCT3_MULHSU) |
                               (funct3 == ISA__FUNCT3_DIV) |
                               (funct3 == ISA__FUNCT3_REM));
        sgn_b  = b[Width-1] & ((funct3 == ISA__FUNCT3_MULH) |
                               (funct3 == ISA__FUNCT3_DIV) |
                               (funct3 == ISA__FUNCT3_REM));
        abs_a  = sgn_a ? -a : a;
        abs_b  = sgn_b ? -b : b;
        // remainder follows the dividend; everything else is sign(a)^sign(b)
        neg_d  = (funct3 == ISA__FUNCT3_REM) ? sgn_a : (sgn_a ^ sgn_b);
`ifdef MULDIV_DIV_EN
        fast_d     = 1'b0;
        fast_res_d = '0;
        if (is_div && (b == '0)) begin
            fast_d     = 1'b1;
            fast_res_d = funct3[1] ? a : '1;
        end else if (is_div && !funct3[0] && (a == MinVal) && (b == '1)) begin
            fast_d     = 1'b1;
            fast_res_d = funct3[1] ? '0 : MinVal;
        end
`else
        fast_d     = is_div;
        fast_res_d = '0;
`endif
    end

    muldiv_step #(
        .Width(Width)
    ) u_step (
`ifdef MULDIV_DIV_EN
        .div_i(op_q[2]),
`endif
        .hi_i (hi_q),
        .lo_i (lo_q),
        .m_i  (m_q),
        .hi_o (hi_d),
        .lo_o (lo_d)
    );

    always_comb begin
        // high half of -{hi,lo}: borrow from the low half only when lo is zero
        hi_neg  = ~hi_d + {{(Width-1){1'b0}}, (lo_d == '0)};
        final_d = neg_q ? hi_neg : hi_d;
        if (op_q == ISA__FUNCT3_MUL) begin
            final_d = lo_d;
        end
`ifdef MULDIV_DIV_EN
        else if (op_q[2]) begin
            if (op_q[1]) final_d = neg_q ? -hi_d : hi_d;
            else         final_d = neg_q ? -lo_d : lo_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && !flush) begin
                        op_q    <= funct3;
                        neg_q   <= neg_d;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (fast_d) begin
                            result_q <= fast_res_d;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            m_q     <= is_div ? abs_b : abs_a;
                            lo_q    <= is_div ? abs_a : abs_b;
                            hi_q    <= '0;
                            cnt_q   <= CntW'(Width);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CntW'(1)) begin
                            result_q <= final_d;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush || rsp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (Width=32).
// Division vectors are selected by MULDIV_DIV_EN, matching the RTL build.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.Width(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .funct3   (funct3),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // lat = clock edges from the accept edge until rsp_valid is seen (0 = fast path)
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input bit consume, output logic [31:0] r, output int lat);
        @(negedge clk);
        funct3 = f; a = x; b = y; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        if (consume) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; funct3 = '0; a = '0; b = '0;
        flush = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul;
        logic [31:0] r;
        int lat;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1, r, lat);
        total++; if (r !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_7_m3 got=%h want=ffffffeb", r); end
        total++; if (lat !== 32) begin bad++; $display("FAIL mul_latency got=%0d want=32", lat); end
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
        total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu_ff got=%h want=fffffffe", r); end
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
        total++; if (r !== 32'h00000000) begin bad++; $display("FAIL mulh_ff got=%h want=00000000", r); end
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulhsu_ff got=%h want=ffffffff", r); end
        run_op(3'd1, 32'h80000000, 32'h00000002, 1'b1, r, lat);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulh_min_2 got=%h want=ffffffff", r); end
        run_op(3'd0, 32'h00010000, 32'h00010001, 1'b1, r, lat);
        total++; if (r !== 32'h00010000) begin bad++; $display("FAIL mul_wrap got=%h want=00010000", r); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        logic [31:0] r;
        int lat;
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat);
        total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_m7_2 got=%h want=fffffffd", r); end
        total++; if (lat !== 32) begin bad++; $display("FAIL div_latency got=%0d want=32", lat); end
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_m7_2 got=%h want=ffffffff", r); end
        run_op(3'd5, 32'd7, 32'd0, 1'b1, r, lat);
        total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_by0 got=%h want=ffffffff", r); end
        total++; if (lat !== 0) begin bad++; $display("FAIL divu_by0_latency got=%0d want=0", lat); end
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL rem_ovf got=%h want=00000000", r); end
        total++; if (lat !== 0) begin bad++; $display("FAIL rem_ovf_latency got=%0d want=0", lat); end
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat);
        total++; if (r !== 32'h80000000) begin bad++; $display("FAIL div_ovf got=%h want=80000000", r); end
        run_op(3'd7, 32'd9, 32'd0, 1'b1, r, lat);
        total++; if (r !== 32'd9) begin bad++; $display("FAIL remu_by0 got=%h want=00000009", r); end
        run_op(3'd5, 32'd100, 32'd7, 1'b1, r, lat);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_100_7 got=%h want=0000000e", r); end
        run_op(3'd7, 32'd100, 32'd7, 1'b1, r, lat);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_100_7 got=%h want=00000002", r); end
        run_op(3'd5, 32'hFFFFFFFF, 32'd2, 1'b1, r, lat);
        total++; if (r !== 32'h7FFFFFFF) begin bad++; $display("FAIL divu_big got=%h want=7fffffff", r); end
    endtask
`else
    task automatic test_div_disabled;
        logic [31:0] r;
        int lat;
        run_op(3'd4, 32'd10, 32'd2, 1'b1, r, lat);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL nodiv_result got=%h want=00000000", r); end
        total++; if (lat !== 0) begin bad++; $display("FAIL nodiv_latency got=%0d want=0", lat); end
        run_op(3'd0, 32'd6, 32'd7, 1'b1, r, lat);
        total++; if (r !== 32'd42) begin bad++; $display("FAIL nodiv_mul got=%h want=0000002a", r); end
        total++; if (lat !== 32) begin bad++; $display("FAIL nodiv_mul_latency got=%0d want=32", lat); end
    endtask
`endif

    task automatic test_hold;
        logic [31:0] r;
        int lat;
        run_op(3'd0, 32'd6, 32'd7, 1'b0, r, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (result !== 32'd42 || rsp_valid !== 1'b1) begin
                bad++; $display("FAIL hold_result cyc=%0d got=%h/%b want=0000002a/1", i, result, rsp_valid);
            end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold_req_ready cyc=%0d got=%b want=0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL hold_release got=v%b r%b b%b want=v0 r1 b0", rsp_valid, req_ready, busy);
        end
        run_op(3'd0, 32'd3, 32'd5, 1'b1, r, lat);
        total++; if (r !== 32'd15 || lat !== 32) begin
            bad++; $display("FAIL hold_next got=%h lat=%0d want=0000000f lat=32", r, lat);
        end
    endtask

    task automatic test_back_to_back;
        int first = -1;
        int second = -1;
        logic [31:0] r1 = '0;
        @(negedge clk);
        funct3 = 3'd0; a = 32'd2; b = 32'd3; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int n = 1; n <= 90 && second < 0; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (first < 0) begin first = n; r1 = result; end
                else second = n;
            end
        end
        req_valid = 1'b0;
        repeat (40) @(negedge clk);
        rsp_ready = 1'b0;
        total++; if (r1 !== 32'd6) begin bad++; $display("FAIL b2b_result got=%h want=00000006", r1); end
        total++; if (second - first !== 34) begin
            bad++; $display("FAIL b2b_period got=%0d want=34", second - first);
        end
    endtask

    task automatic test_flush;
        int seen = 0;
        @(negedge clk);
        funct3 = 3'd0; a = 32'd9; b = 32'd9; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL flush_calc got=b%b r%b v%b want=b0 r1 v0", busy, req_ready, rsp_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_no_rsp got=%0d want=0", seen); end
        req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL flush_idle got=b%b r%b want=b0 r1", busy, req_ready);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clk);
        funct3 = 3'd0; a = 32'd5; b = 32'd5; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_ctrl got=r%b v%b b%b want=r1 v0 b0", req_ready, rsp_valid, busy);
        end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_rsp got=%0d want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
`ifdef MULDIV_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
